// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetches 32-bit instruction pairs from instruction memory into a 2-entry
//   FIFO and presents the head pair to the prefetch buffer. A redirect flushes
//   the FIFO, retargets the fetch PC and, for an odd target, marks the low
//   halfword of the first new pair for discard.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   ready        in   prefetch buffer accepts one pair this cycle
//   redirect     in   taken jump/branch: flush and refetch
//   redirect_pc  in   [15:0] halfword index of the target instruction
//   imem_req     out  read request, accepted in the cycle it is high
//   imem_addr    out  [14:0] word address (fetch_pc[15:1])
//   imem_valid   in   read response strobe
//   imem_rdata   in   [31:0] instruction pair, [15:0] first
//   exInst       out  [31:0] head instruction pair
//   write        out  exInst valid; transfers when write && ready
//   PCNI         out  [15:0] halfword index of first valid instruction
//   skip_lo      out  exInst[15:0] is to be discarded
//
// Optional feature (macro FETCH_STAT_EN)
//   fetch_count  out  [15:0] pushed entries, saturating
//   flush_count  out  [15:0] redirect cycles, saturating
// ----------------------------------------------------------------------------
module instr_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [14:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] exInst,
    output logic        write,
    output logic [15:0] PCNI,
    output logic        skip_lo
`ifdef FETCH_STAT_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

    state_e      r_state;
    logic [15:0] r_fetch_pc;
    logic        r_skip_pend;
    logic [1:0]  r_count;
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [31:0] r_pair [2];
    logic [15:0] r_pcni [2];
    logic        r_skip [2];

    logic w_req;
    logic w_push;
    logic w_pop;

    // Requests only go out when a slot is free without counting on a pop, so
    // the single outstanding response always has room.
    assign w_req  = rst && (r_state == StIdle) && (r_count < 2'd2) && !redirect;
    assign w_push = (r_state == StWait) && imem_valid && !redirect;
    assign w_pop  = (r_count != 2'd0) && ready;

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc[15:1];

    assign write   = (r_count != 2'd0);
    assign exInst  = write ? r_pair[r_rd_ptr] : 32'h0;
    assign PCNI    = write ? r_pcni[r_rd_ptr] : 16'h0;
    assign skip_lo = write ? r_skip[r_rd_ptr] : 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_fetch_pc  <= 16'h0;
            r_skip_pend <= 1'b0;
            r_count     <= 2'd0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
        end else if (redirect) begin
            r_count     <= 2'd0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_fetch_pc  <= redirect_pc & 16'hFFFE;
            r_skip_pend <= redirect_pc[0];
            // A response landing in the redirect cycle is simply dropped;
            // otherwise an in-flight request must be drained in DISCARD.
            if (r_state != StIdle) begin
                r_state <= imem_valid ? StIdle : StDiscard;
            end
        end else begin
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_req) begin
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (imem_valid) begin
                        r_wr_ptr    <= ~r_wr_ptr;
                        r_fetch_pc  <= r_fetch_pc + 16'd2;
                        r_skip_pend <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                StDiscard: begin
                    if (imem_valid) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Payload storage needs no reset: outputs are gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pair[r_wr_ptr] <= imem_rdata;
            // fetch_pc is even, so bit 0 carries the odd-target flag.
            r_pcni[r_wr_ptr] <= {r_fetch_pc[15:1], r_skip_pend};
            r_skip[r_wr_ptr] <= r_skip_pend;
        end
    end

`ifdef FETCH_STAT_EN
    logic [15:0] r_fetch_count;
    logic [15:0] r_flush_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_count <= 16'h0;
            r_flush_count <= 16'h0;
        end else begin
            if (w_push && (r_fetch_count != 16'hFFFF)) begin
                r_fetch_count <= r_fetch_count + 16'd1;
            end
            if (redirect && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign flush_count = r_flush_count;
`endif

endmodule
